score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl.sv | 102 ++++++++++
 tb/tb_score_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: whack-a-mole round controller with round-robin hit arbitration,
// a shared saturating BCD score adder and a one-second round timer.
module score_ctrl #(
    parameter int N_MOLES     = 4,
    parameter int ROUND_SECS  = 60,
    parameter int PTS_PER_HIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tick_1hz,
    input  logic [N_MOLES-1:0] hit_req,
    input  logic [N_MOLES-1:0] mole_up,
    output logic [N_MOLES-1:0] hit_ack,
    output logic [15:0]        points,
    output logic [6:0]         time_left,
    output logic               running,
    output logic               game_over
);
    localparam int PW = $clog2(N_MOLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [PW-1:0]  ptr, idx, gnt_idx, ptr_n;
    logic           found;
    logic [N_MOLES-1:0] elig;
    logic [4:0]     dsum;
    logic           cy;
    logic [15:0]    bsum, bcd_next;

    assign running   = state == RUN;
    assign game_over = state == DONE;

    always_comb begin
        state_n = state;
        if (state != RUN && start)
            state_n = RUN;
        else if (state == RUN && tick_1hz && time_left == 7'd1)
            state_n = DONE;
    end

    // A request that is being acknowledged this cycle sits out one arbitration.
    always_comb begin
        elig    = hit_req & ~hit_ack;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = ptr;
        for (int k = 0; k < N_MOLES; k++) begin
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
            idx = (idx == PW'(N_MOLES - 1)) ? '0 : idx + 1'b1;
        end
        ptr_n = (gnt_idx == PW'(N_MOLES - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        cy   = 1'b0;
        bsum = '0;
        dsum = '0;
        for (int d = 0; d < 4; d++) begin
            dsum = {1'b0, points[4*d+:4]} + (d == 0 ? 5'(PTS_PER_HIT) : 5'd0) + {4'd0, cy};
            cy   = dsum > 5'd9;
            bsum[4*d+:4] = cy ? 4'(dsum - 5'd10) : dsum[3:0];
        end
        bcd_next = cy ? 16'h9999 : bsum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            points    <= '0;
            time_left <= '0;
            hit_ack   <= '0;
            ptr       <= '0;
        end else begin
            hit_ack <= '0;
            if (state != RUN && start) begin
                points    <= '0;
                time_left <= 7'(ROUND_SECS);
                ptr       <= '0;
            end else if (state == RUN) begin
                if (found) begin
                    hit_ack <= N_MOLES'(1) << gnt_idx;
                    ptr     <= ptr_n;
                    if (mole_up[gnt_idx])
                        points <= bcd_next;
                end
                if (tick_1hz && time_left != 7'd0)
                    time_left <= time_left - 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: table vectors, directed corner sequences and random stimulus
// checked against an integer-arithmetic model of the round/score rules.
module tb_score_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] hit_req = '0;
    logic [3:0] mole_up = '0;
    logic [3:0] hit_ack;
    logic [15:0] points;
    logic [6:0] time_left;
    logic       running, game_over;

    int n_chk = 0;
    int n_fail = 0;

    bit   m_run, m_over;
    int   m_score, m_time, m_next;
    logic [3:0] m_ack;

    typedef struct {
        logic st, tk;
        logic [3:0] rq, up, ack;
        logic [15:0] pts;
        logic [6:0] tl;
        logic run, over;
    } vec_t;
    vec_t tbl[10];

    score_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick_1hz(tick_1hz),
        .hit_req(hit_req), .mole_up(mole_up), .hit_ack(hit_ack),
        .points(points), .time_left(time_left), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_over = 0; m_score = 0; m_time = 0; m_next = 0; m_ack = '0;
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic step(logic st, logic tk, logic [3:0] rq, logic [3:0] up);
        logic [3:0] na;
        start = st; tick_1hz = tk; hit_req = rq; mole_up = up;
        na = '0;
        if (m_run) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_next + k) % 4;
                if (na == 0 && rq[j] && !m_ack[j]) begin
                    na[j] = 1'b1;
                    m_next = (j + 1) % 4;
                    if (up[j]) m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
                end
            end
            if (tk && m_time > 0) begin
                m_time--;
                if (m_time == 0) begin m_run = 0; m_over = 1; end
            end
        end else if (st) begin
            m_run = 1; m_over = 0; m_score = 0; m_time = 60; m_next = 0;
        end
        m_ack = na;
        @(posedge clk);
        #1;
        chk("ack", hit_ack, m_ack);
        chk("points", points, bcd(m_score));
        chk("time_left", time_left, m_time);
        chk("running", running, m_run);
        chk("game_over", game_over, m_over);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        start = 0; tick_1hz = 0; hit_req = '0; mole_up = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 16'h0000, 7'd60, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h1, 16'h0001, 7'd60, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h2, 16'h0002, 7'd60, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h4, 16'h0003, 7'd60, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h8, 16'h0004, 7'd60, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h1, 16'h0005, 7'd60, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h4, 16'h0005, 7'd60, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 16'h0005, 7'd60, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0005, 7'd60, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0005, 7'd59, 1'b1, 1'b0};

        model_reset();
        #3;
        chk("rst_points", points, 16'h0000);
        chk("rst_time", time_left, 7'd0);
        chk("rst_ack", hit_ack, 4'h0);
        chk("rst_running", running, 1'b0);
        chk("rst_over", game_over, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, tbl[i].tk, tbl[i].rq, tbl[i].up);
            chk($sformatf("tbl%0d_ack", i), hit_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_pts", i), points, tbl[i].pts);
            chk($sformatf("tbl%0d_tl", i), time_left, tbl[i].tl);
            chk($sformatf("tbl%0d_run", i), running, tbl[i].run);
            chk($sformatf("tbl%0d_over", i), game_over, tbl[i].over);
        end

        // Full round timing
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            step(0, 1, 0, 0);
            if (i < 60) chk("round_running", running, 1'b1);
        end
        chk("round_time0", time_left, 7'd0);
        chk("round_over", game_over, 1'b1);
        step(0, 0, 4'hF, 4'hF);
        chk("done_no_ack", hit_ack, 4'h0);
        chk("done_hold", points, 16'h0000);

        // Final tick coinciding with a valid hit
        step(1, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
        chk("pre_final_time", time_left, 7'd1);
        step(0, 1, 4'h1, 4'h1);
        chk("final_hit_pts", points, 16'h0001);
        chk("final_hit_ack", hit_ack, 4'h1);
        chk("final_hit_over", game_over, 1'b1);
        step(0, 0, 4'h2, 4'h2);
        chk("after_done_ack", hit_ack, 4'h0);
        chk("after_done_pts", points, 16'h0001);

        // BCD carry and saturation
        step(1, 0, 0, 0);
        while (m_score < 99) step(0, 0, 4'hF, 4'hF);
        chk("pre_carry", points, 16'h0099);
        step(0, 0, 4'hF, 4'hF);
        chk("carry_0100", points, 16'h0100);
        while (m_score < 9999) step(0, 0, 4'hF, 4'hF);
        chk("at_9999", points, 16'h9999);
        step(0, 0, 4'hF, 4'hF);
        chk("sat_9999", points, 16'h9999);

        // Asynchronous reset mid-round
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 37; i++) step(0, 0, 4'hF, 4'hF);
        chk("pre_rst_pts", points, 16'h0037);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_points", points, 16'h0000);
        chk("arst_running", running, 1'b0);
        chk("arst_ack", hit_ack, 4'h0);
        chk("arst_over", game_over, 1'b0);
        model_reset();
        start = 0; hit_req = '0; mole_up = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
